// File: rtl/dmem_block_mover.sv
// Block copy/fill initiator for the data memory port: walks source and destination
// pointers word by word and drives Address/WriteData/MemWrite from registered state.
module dmem_block_mover #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Start,
  input  logic                     Mode,
  input  logic [ADDRESS_WIDTH-1:0] SrcAddr,
  input  logic [ADDRESS_WIDTH-1:0] DstAddr,
  input  logic [ADDRESS_WIDTH-1:0] Count,
  input  logic [DATA_WIDTH-1:0]    FillData,
  output logic [ADDRESS_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0]    WriteData,
  output logic                     MemWrite,
  input  logic [DATA_WIDTH-1:0]    MemData,
  output logic                     Busy,
  output logic                     Done
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

  state_t                   state;
  logic                     mode_q;
  logic [ADDRESS_WIDTH-1:0] src_ptr;
  logic [ADDRESS_WIDTH-1:0] dst_ptr;
  logic [ADDRESS_WIDTH-1:0] remaining;
  logic [DATA_WIDTH-1:0]    pattern;

  // Outputs are loaded together with the state they belong to, so they are
  // plain registers; the WriteData register doubles as the copy read buffer.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      pattern   <= '0;
      Address   <= '0;
      WriteData <= '0;
      MemWrite  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            mode_q    <= Mode;
            src_ptr   <= SrcAddr;
            dst_ptr   <= DstAddr;
            remaining <= Count;
            pattern   <= FillData;
            if (Count == '0) begin
              state <= DONE;
              Done  <= 1'b1;
            end else if (!Mode) begin
              state   <= READ;
              Address <= SrcAddr;
              Busy    <= 1'b1;
            end else begin
              state     <= WRITE;
              Address   <= DstAddr;
              WriteData <= FillData;
              MemWrite  <= 1'b1;
              Busy      <= 1'b1;
            end
          end
        end

        READ: begin
          state     <= WRITE;
          src_ptr   <= src_ptr + ADDR_ONE;
          Address   <= dst_ptr;
          WriteData <= MemData;
          MemWrite  <= 1'b1;
        end

        WRITE: begin
          dst_ptr   <= dst_ptr + ADDR_ONE;
          remaining <= remaining - ADDR_ONE;
          if (remaining == ADDR_ONE) begin
            state     <= DONE;
            Address   <= '0;
            WriteData <= '0;
            MemWrite  <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b1;
          end else if (!mode_q) begin
            state     <= READ;
            Address   <= src_ptr;
            WriteData <= '0;
            MemWrite  <= 1'b0;
          end else begin
            Address   <= dst_ptr + ADDR_ONE;
            WriteData <= pattern;
          end
        end

        DONE: begin
          state <= IDLE;
          Done  <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          Address   <= '0;
          WriteData <= '0;
          MemWrite  <= 1'b0;
          Busy      <= 1'b0;
          Done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_block_mover.sv
// Scoreboard bench for dmem_block_mover: a word-level reference memory predicts every
// write; a monitor checks each DUT write against the queue and counts Done pulses.
module tb_dmem_block_mover;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Rst, Start, Mode;
  logic [AW-1:0] SrcAddr, DstAddr, Count, Address;
  logic [DW-1:0] FillData, WriteData, MemData;
  logic          MemWrite, Busy, Done;

  always #5 Clk = ~Clk;

  dmem_block_mover #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Mode(Mode),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Count(Count), .FillData(FillData),
    .Address(Address), .WriteData(WriteData), .MemWrite(MemWrite),
    .MemData(MemData), .Busy(Busy), .Done(Done)
  );

  logic [DW-1:0] mem     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  assign MemData = mem[Address];
  always @(posedge Clk) if (MemWrite === 1'b1) mem[Address] <= WriteData;

  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  wr_t expq[$];

  int unsigned n_cmp = 0, n_bad = 0;
  int unsigned done_seen = 0, done_exp = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every write presented by the DUT must be the next predicted one.
  always @(negedge Clk) begin
    if (MemWrite === 1'b1) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got write to %0h data %0h, expected none", Address, WriteData);
      end else begin
        wr_t w;
        w = expq.pop_front();
        check("wr_addr", 64'(Address), 64'(w.a));
        check("wr_data", 64'(WriteData), 64'(w.d));
      end
    end
    if (Done === 1'b1) done_seen++;
  end

  // Reference model: forward, word-at-a-time copy/fill on the reference memory.
  task automatic issue(input bit mode, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                       input logic [AW-1:0] cnt, input logic [DW-1:0] fill,
                       input int unsigned model_cnt);
    for (int unsigned k = 0; k < model_cnt; k++) begin
      logic [AW-1:0] a, s;
      logic [DW-1:0] v;
      a = dst + k[AW-1:0];
      s = src + k[AW-1:0];
      v = mode ? fill : ref_mem[s];
      ref_mem[a] = v;
      expq.push_back('{a: a, d: v});
    end
    if (model_cnt == 32'(cnt)) done_exp++;
    @(negedge Clk);
    Start = 1'b1; Mode = mode; SrcAddr = src; DstAddr = dst; Count = cnt; FillData = fill;
    @(posedge Clk);
  endtask

  // Issue a command and check Busy/MemWrite/Done cycle by cycle; optionally pulse
  // Start while busy and in DONE with different arguments.
  task automatic run(input bit mode, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                     input logic [AW-1:0] cnt, input logic [DW-1:0] fill, input bit poke);
    int unsigned len;
    issue(mode, src, dst, cnt, fill, 32'(cnt));
    len = (cnt == 0) ? 0 : (mode ? 32'(cnt) : 2 * 32'(cnt));
    for (int unsigned c = 1; c <= len + 2; c++) begin
      logic mw;
      @(negedge Clk);
      Start = 1'b0;
      SrcAddr = AW'($urandom); DstAddr = AW'($urandom); Count = AW'($urandom);
      FillData = $urandom; Mode = 1'($urandom);
      mw = (c <= len) && (mode || (c % 2 == 0));
      check($sformatf("timing_c%0d_n%0d", c, cnt), 64'({Busy, MemWrite, Done}),
            64'({c <= len, mw, c == len + 1}));
      if (poke && (c == 2 || c == len + 1)) Start = 1'b1;
    end
    Start = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] m7, m12;
    int unsigned diffs;
    Rst = 1'b1; Start = 1'b0; Mode = 1'b0;
    SrcAddr = '0; DstAddr = '0; Count = '0; FillData = '0;
    for (int unsigned i = 0; i < 65536; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_outputs", 64'({Address, WriteData, MemWrite, Busy, Done}), 64'(0));
    Rst = 1'b0;

    // Copy 4..6 -> 20..22
    mem[4] = 32'hA; mem[5] = 32'hB; mem[6] = 32'hC;
    ref_mem[4] = 32'hA; ref_mem[5] = 32'hB; ref_mem[6] = 32'hC;
    run(1'b0, 16'd4, 16'd20, 16'd3, 32'h0, 1'b0);
    check("copy_dst0", 64'(mem[20]), 64'hA);
    check("copy_dst1", 64'(mem[21]), 64'hB);
    check("copy_dst2", 64'(mem[22]), 64'hC);
    check("copy_src_kept", 64'({mem[4][3:0], mem[5][3:0], mem[6][3:0]}), 64'h0ABC);

    // Fill 8..11
    m7 = mem[7]; m12 = mem[12];
    run(1'b1, 16'd0, 16'd8, 16'd4, 32'hDEADBEEF, 1'b0);
    for (int unsigned i = 8; i < 12; i++) check($sformatf("fill_%0d", i), 64'(mem[i]), 64'hDEADBEEF);
    check("fill_below", 64'(mem[7]), 64'(m7));
    check("fill_above", 64'(mem[12]), 64'(m12));

    // Zero-length commands
    run(1'b0, 16'd4, 16'd30, 16'd0, 32'h0, 1'b0);
    run(1'b1, 16'd0, 16'd30, 16'd0, 32'h1234, 1'b0);

    // Overlapping forward copy replicates the first source word
    mem[2] = 32'h55; mem[3] = 32'h66; ref_mem[2] = 32'h55; ref_mem[3] = 32'h66;
    run(1'b0, 16'd2, 16'd3, 16'd2, 32'h0, 1'b0);
    check("overlap_3", 64'(mem[3]), 64'h55);
    check("overlap_4", 64'(mem[4]), 64'h55);

    // Address wrap
    run(1'b1, 16'd0, 16'hFFFF, 16'd2, 32'd7, 1'b0);
    check("wrap_ffff", 64'(mem[16'hFFFF]), 64'd7);
    check("wrap_0000", 64'(mem[0]), 64'd7);

    // Reset mid-fill: two words written, then everything back to reset values
    issue(1'b1, 16'd0, 16'd40, 16'd4, 32'h12345678, 2);
    @(negedge Clk); Start = 1'b0;
    check("rst_fill_c1", 64'({Busy, MemWrite, Done}), 64'b110);
    @(negedge Clk);
    check("rst_fill_c2", 64'({Busy, MemWrite, Done}), 64'b110);
    Rst = 1'b1;
    @(negedge Clk);
    check("rst_fill_c3", 64'({Address, WriteData, MemWrite, Busy, Done}), 64'(0));
    Rst = 1'b0;
    for (int unsigned c = 0; c < 3; c++) begin
      @(negedge Clk);
      check("rst_after", 64'({Busy, MemWrite, Done}), 64'(0));
    end

    // Start pulses while busy and in DONE are ignored
    run(1'b0, 16'd30, 16'd50, 16'd3, 32'h0, 1'b1);

    // Randomized commands
    for (int unsigned t = 0; t < 30; t++) begin
      bit            md;
      logic [AW-1:0] s, d, n;
      md = 1'($urandom);
      s  = AW'($urandom_range(0, 80));
      d  = ($urandom_range(0, 3) == 0) ? 16'hFFFD : AW'($urandom_range(0, 80));
      n  = AW'($urandom_range(0, 6));
      run(md, s, d, n, $urandom, 1'($urandom));
    end

    repeat (2) @(negedge Clk);
    check("writes_pending", 64'(expq.size()), 64'(0));
    check("done_pulses", 64'(done_seen), 64'(done_exp));
    diffs = 0;
    for (int unsigned i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("mem_image_diffs", 64'(diffs), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running, expected to finish");
    $fatal(1, "timeout");
  end

endmodule
